// File: rtl/tama_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tama_pkg
// Brief    : Shared command bytes, receiver FSM states and command check.
// Revision : 1.0 - initial release
// ============================================================================
package tama_pkg;

   localparam logic [7:0] CMD_EAT    = 8'h65;
   localparam logic [7:0] CMD_PLAY   = 8'h70;
   localparam logic [7:0] CMD_DOCTOR = 8'h64;
   localparam logic [7:0] CMD_BATH   = 8'h62;
   localparam logic [7:0] CMD_SLEEP  = 8'h73;
   localparam logic [7:0] CMD_TALK   = 8'h74;
   localparam logic [7:0] CMD_WAKE   = 8'h77;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_t;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_EAT)   || (b == CMD_PLAY)  || (b == CMD_DOCTOR) ||
             (b == CMD_BATH)  || (b == CMD_SLEEP) || (b == CMD_TALK)   ||
             (b == CMD_WAKE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop single-bit synchronizer with configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Brief    : 8N1 UART command receiver with hold-window level output.
//            Define UART_CMD_FILTER_EN to accept only known command bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_rx
   import tama_pkg::*;
#(
   parameter int CLK_HZ      = 27_000_000,
   parameter int BAUD        = 115_200,
   parameter int HOLD_CYCLES = 27_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] cmd,
   output logic       cmd_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HW  = $clog2(HOLD_CYCLES);

   localparam logic [TW-1:0] C_DIV_LAST  = TW'(DIV - 1);
   localparam logic [TW-1:0] C_HALF_LAST = TW'(DIV / 2 - 1);
   localparam logic [HW-1:0] C_HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   logic            w_rxs;
   rx_state_t       r_state;
   logic [TW-1:0]   r_timer;
   logic [2:0]      r_index;
   logic [7:0]      r_shift;
   logic [HW-1:0]   r_hold_cnt;
   logic            r_hold_active;
   logic            r_pend;
   logic [7:0]      r_pend_byte;
   logic            w_bit_end;
   logic            w_keep;
   logic            w_accept;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (w_rxs)
   );

   assign w_bit_end = (r_timer == C_DIV_LAST);

`ifdef UART_CMD_FILTER_EN
   assign w_keep = is_cmd(r_shift);
`else
   assign w_keep = (r_shift != 8'h00);
`endif

   // The full byte is already in r_shift while the stop bit is being sampled.
   assign w_accept = (r_state == ST_STOP) && w_bit_end && w_rxs && w_keep;
   assign busy     = (r_state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_timer   <= '0;
         r_index   <= '0;
         r_shift   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_rxs) begin
                  r_state <= ST_START;
                  r_timer <= '0;
               end
            end
            ST_START: begin
               if (r_timer == C_HALF_LAST) begin
                  if (w_rxs) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_DATA;
                     r_timer <= '0;
                     r_index <= '0;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_shift <= {w_rxs, r_shift[7:1]};
                  r_timer <= '0;
                  r_index <= r_index + 1'b1;
                  if (r_index == 3'd7) begin
                     r_state <= ST_STOP;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  r_timer <= '0;
                  if (w_rxs) begin
                     r_state <= ST_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     r_state   <= ST_WAIT_HIGH;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_WAIT_HIGH: begin
               if (w_rxs) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A command arriving during a hold first drops cmd to 0x00 for one cycle
   // so the stats block sees a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd           <= 8'h00;
         cmd_valid     <= 1'b0;
         r_hold_cnt    <= '0;
         r_hold_active <= 1'b0;
         r_pend        <= 1'b0;
         r_pend_byte   <= 8'h00;
      end else begin
         cmd_valid <= 1'b0;
         if (w_accept) begin
            if (r_hold_active) begin
               cmd         <= 8'h00;
               r_pend      <= 1'b1;
               r_pend_byte <= r_shift;
            end else begin
               cmd           <= r_shift;
               cmd_valid     <= 1'b1;
               r_hold_cnt    <= C_HOLD_LOAD;
               r_hold_active <= 1'b1;
            end
         end else if (r_pend) begin
            cmd           <= r_pend_byte;
            cmd_valid     <= 1'b1;
            r_hold_cnt    <= C_HOLD_LOAD;
            r_hold_active <= 1'b1;
            r_pend        <= 1'b0;
         end else if (r_hold_active) begin
            if (r_hold_cnt == '0) begin
               cmd           <= 8'h00;
               r_hold_active <= 1'b0;
            end else begin
               r_hold_cnt <= r_hold_cnt - 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver feeding the tamagotchi stats block. Decodes 8N1 UART frames from the host line, keeps only meaningful command bytes, and presents each command on an 8-bit level output for a fixed hold window before returning it to 0x00. The 0x00 return re-arms the stats block's one-command-per-press guard.

## Interface
- `CLK_HZ`, 27_000_000, system clock frequency.
- `BAUD`, 115_200, line rate; `DIV = CLK_HZ/BAUD`, truncated (234 at defaults).
- `HOLD_CYCLES`, 27_000, cycles a command stays on `cmd` (1 ms at defaults); must be ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rx`  in  1  asynchronous UART line, idle high.
- `cmd`  out  8  current command byte, 0x00 when none; drives the stats block's `inputs`.
- `cmd_valid`  out  1  one-cycle pulse on the cycle a new byte first appears on `cmd`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `busy`  out  1  high while a frame is being decoded (any state other than IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer that resets to 1. All decoding uses the synchronized signal `rxs`.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH. One bit-timer counts 0..DIV-1, and one 3-bit index tracks the data bit.
- IDLE: on `rxs`=0, go to START and clear the timer.
- START: when the timer reaches DIV/2-1, sample `rxs`.
  - If the sample is 1 (false start), return to IDLE.
  - Otherwise clear the timer and index, and go to DATA.
- DATA: each time the timer reaches DIV-1, sample `rxs` into the shift register, LSB first. After index 7, go to STOP.
- STOP: when the timer reaches DIV-1, sample `rxs`.
  - If 1, the byte is accepted; go to IDLE.
  - If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`=1, then go to IDLE. No start bit is detected until the line has returned high.
- Acceptance filter:
  - A byte of 0x00 is always dropped.
  - Other drops depend on `CMD_FILTER_EN` (see Configuration).
  - A dropped byte produces no `cmd_valid` pulse and leaves `cmd` and the hold counter untouched.
- Output stage, with the hold counter idle:
  - An accepted byte is loaded into `cmd`, `cmd_valid` pulses, and the hold counter loads HOLD_CYCLES-1.
  - The counter decrements every cycle. On the cycle after it reaches 0, `cmd` returns to 0x00.
- New accept while the hold counter is active:
  - `cmd` is forced to 0x00 for exactly one cycle (gap insertion).
  - On the following cycle the new byte appears with `cmd_valid`, and the hold restarts.
- The receiver keeps decoding during the hold; the output stage never back-pressures it.
- Reset, including mid-frame or mid-hold:
  - FSM goes to IDLE; timers and index clear.
  - `cmd`=0x00, `cmd_valid`=0, `frame_err`=0, `busy`=0, synchronizer flops=1.

## Timing
- Synchronizer latency: 2 cycles from an `rx` edge to `rxs`.
- The start bit is verified DIV/2 cycles after its detected falling edge. Data and stop bits are sampled at DIV-cycle spacing after that.
- `cmd` and `cmd_valid` update 1 cycle after the stop-bit sample cycle, or 2 cycles when gap insertion applies.
- `cmd` is non-zero for exactly HOLD_CYCLES cycles per command when uninterrupted.
- `frame_err` asserts 1 cycle after the stop-bit sample cycle.
- `busy` rises the cycle after IDLE sees `rxs`=0. It falls on the cycle the FSM enters IDLE.
- Baud truncation error must stay below 2% of the bit period; at the defaults it is 0.16%.

## Configuration
- `UART_CMD_FILTER_EN` defined:
  - Only the command characters 0x65 'e', 0x70 'p', 0x64 'd', 0x62 'b', 0x73 's', 0x74 't' and 0x77 'w' are accepted.
  - All other bytes are dropped silently.
- `UART_CMD_FILTER_EN` undefined: every non-zero byte is accepted and forwarded.

## Structure
- Shared package `tama_pkg`:
  - Command byte constants `CMD_EAT`, `CMD_PLAY`, `CMD_DOCTOR`, `CMD_BATH`, `CMD_SLEEP`, `CMD_TALK`, `CMD_WAKE`.
  - The FSM state enum.
  - Function `is_cmd(byte)`, used by the filter and by the stats block.
- One sub-module, `sync_2ff`: a parameterizable-reset-value bit synchronizer, instantiated for `rx` with reset value 1.
- Bit timer, FSM, filter and hold logic stay in `uart_cmd_rx`.

## Test plan
- Send a clean 'e' (0x65) at 234 cycles/bit → `cmd`=0x65 for exactly 27_000 cycles, then 0x00; one `cmd_valid` pulse; `frame_err` never asserts.
- Pulse `rx` low for 50 cycles only → false start, FSM returns to IDLE; `cmd` stays 0x00 with no `cmd_valid`.
- Send 'p' with the stop bit forced low → one `frame_err` pulse; `cmd` stays 0x00. A following clean 's' is accepted only after the line has returned high.
- Send 'e' then immediately 't' (about 2_340 cycles later, inside the hold) → `cmd` shows 0x65, then exactly one cycle of 0x00, then 0x74 for 27_000 cycles; two `cmd_valid` pulses.
- Send 0x41 'A' and 0x00 → with `UART_CMD_FILTER_EN`, both are dropped; without it, 0x41 is forwarded and 0x00 is still dropped.
- Assert `reset` during DATA bit 4 of 'd' and again mid-hold → all outputs return to reset values immediately. A clean 'b' after release yields `cmd`=0x62.
